// File: rtl/hazard_scoreboard_unit.sv
// Hazard and forwarding control for the 5-stage pipeline, with a per-register
// scoreboard tracking outstanding multiply/divide results.
module hazard_scoreboard_unit #(
  parameter int NREG         = 32,
  parameter int MAX_INFLIGHT = 4,
  parameter int CNTW         = 16,
  localparam int RW          = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [RW-1:0]   Rs1D,
  input  logic [RW-1:0]   Rs2D,
  input  logic [RW-1:0]   RdD,
  input  logic            LongD,
  input  logic [RW-1:0]   Rs1E,
  input  logic [RW-1:0]   Rs2E,
  input  logic [RW-1:0]   RdE,
  input  logic            RegWriteE,
  input  logic            LoadE,
  input  logic            LongE,
  input  logic [RW-1:0]   RdM,
  input  logic            RegWriteM,
  input  logic [RW-1:0]   RdW,
  input  logic            RegWriteW,
  input  logic            PCSrcE,
  input  logic            MduDone,
  input  logic [RW-1:0]   MduRd,
  output logic [1:0]      ForwardAE,
  output logic [1:0]      ForwardBE,
  output logic            StallF,
  output logic            StallD,
  output logic            FlushD,
  output logic            FlushE,
  output logic [NREG-1:0] SbBusy,
  output logic [3:0]      InflightCnt,
  output logic [CNTW-1:0] StallCycles,
  output logic            SbErr
);

  logic            lwStall;
  logic            sbHit;
  logic            longHit;
  logic            fullStall;
  logic            stall;
  logic            issueWrite;
  logic            doneOk;
  logic            errEvent;
  logic [4:0]      pending;
  logic [3:0]      cntNext;
  logic [NREG-1:0] busyNext;

  // Memory-stage result is newer than Writeback, so it takes priority.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RegWriteM && (RdM != '0) && (RdM == Rs1E))
      ForwardAE = 2'b10;
    else if (RegWriteW && (RdW != '0) && (RdW == Rs1E))
      ForwardAE = 2'b01;
    if (RegWriteM && (RdM != '0) && (RdM == Rs2E))
      ForwardBE = 2'b10;
    else if (RegWriteW && (RdW != '0) && (RdW == Rs2E))
      ForwardBE = 2'b01;
  end

  always_comb begin
    lwStall   = LoadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
    sbHit     = ((Rs1D != '0) && SbBusy[Rs1D]) ||
                ((Rs2D != '0) && SbBusy[Rs2D]) ||
                ((RdD  != '0) && SbBusy[RdD]);
    // An op issuing this cycle is not in the scoreboard yet.
    longHit   = LongE && RegWriteE && (RdE != '0) &&
                ((RdE == Rs1D) || (RdE == Rs2D) || (RdE == RdD));
    pending   = {1'b0, InflightCnt} + {4'b0000, LongE};
    fullStall = LongD && (pending >= 5'(MAX_INFLIGHT));
    stall     = lwStall || sbHit || longHit || fullStall;
    StallF    = stall;
    StallD    = stall;
    FlushD    = PCSrcE;
    FlushE    = stall || PCSrcE;
  end

  // Completion clears before issue sets, so a same-register collision keeps the bit.
  always_comb begin
    issueWrite = LongE && RegWriteE && (RdE != '0);
    doneOk     = MduDone && (InflightCnt != 4'd0);
    errEvent   = MduDone && ((InflightCnt == 4'd0) ||
                             ((MduRd != '0) && !SbBusy[MduRd]));
    busyNext   = SbBusy;
    if (doneOk)
      busyNext[MduRd] = 1'b0;
    if (issueWrite)
      busyNext[RdE] = 1'b1;
    busyNext[0] = 1'b0;
    cntNext = InflightCnt;
    if (LongE && !doneOk)
      cntNext = InflightCnt + 4'd1;
    else if (!LongE && doneOk)
      cntNext = InflightCnt - 4'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      SbBusy      <= '0;
      InflightCnt <= 4'd0;
      StallCycles <= '0;
      SbErr       <= 1'b0;
    end else begin
      SbBusy      <= busyNext;
      InflightCnt <= cntNext;
      if (stall && (StallCycles != '1))
        StallCycles <= StallCycles + CNTW'(1);
      if (errEvent)
        SbErr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit: stimulus pushes expectations into
// a queue that a negedge monitor drains and compares.
module tb_hazard_scoreboard_unit;

  localparam int RW = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic [RW-1:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW, MduRd;
  logic        LongD, RegWriteE, LoadE, LongE, RegWriteM, RegWriteW, PCSrcE, MduDone;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, FlushD, FlushE, SbErr;
  logic [31:0] SbBusy;
  logic [3:0]  InflightCnt;
  logic [15:0] StallCycles;

  hazard_scoreboard_unit #(.NREG(32), .MAX_INFLIGHT(4), .CNTW(16)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .LongD(LongD),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RegWriteE(RegWriteE),
    .LoadE(LoadE), .LongE(LongE),
    .RdM(RdM), .RegWriteM(RegWriteM), .RdW(RdW), .RegWriteW(RegWriteW),
    .PCSrcE(PCSrcE), .MduDone(MduDone), .MduRd(MduRd),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .SbBusy(SbBusy), .InflightCnt(InflightCnt), .StallCycles(StallCycles),
    .SbErr(SbErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  mask;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        stall;
    logic        fD;
    logic        fE;
    logic [31:0] busy;
    logic [3:0]  cnt;
    logic [15:0] sc;
    logic        err;
  } expT;

  expT   expQ[$];
  string nameQ[$];
  int    checks = 0;
  int    errors = 0;

  task automatic compareField(input string name, input string field,
                              input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s.%s: got %0h, expected %0h", name, field, act, req);
    end
  endtask

  // Monitor: everything queued during a cycle is compared on its falling edge.
  always @(negedge clk) begin
    expT   e;
    string n;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      n = nameQ.pop_front();
      if (e.mask[0]) begin
        compareField(n, "ForwardAE", 32'(ForwardAE), 32'(e.fa));
        compareField(n, "ForwardBE", 32'(ForwardBE), 32'(e.fb));
      end
      if (e.mask[1]) begin
        compareField(n, "StallF", 32'(StallF), 32'(e.stall));
        compareField(n, "StallD", 32'(StallD), 32'(e.stall));
        compareField(n, "FlushD", 32'(FlushD), 32'(e.fD));
        compareField(n, "FlushE", 32'(FlushE), 32'(e.fE));
      end
      if (e.mask[2]) compareField(n, "SbBusy", SbBusy, e.busy);
      if (e.mask[3]) compareField(n, "InflightCnt", 32'(InflightCnt), 32'(e.cnt));
      if (e.mask[4]) compareField(n, "StallCycles", 32'(StallCycles), 32'(e.sc));
      if (e.mask[5]) compareField(n, "SbErr", 32'(SbErr), 32'(e.err));
    end
  end

  task automatic checkOutput(input string name, input logic [5:0] mask,
                             input logic [1:0] fa, input logic [1:0] fb,
                             input logic stall, input logic fD, input logic fE,
                             input logic [31:0] busy, input logic [3:0] cnt,
                             input logic [15:0] sc, input logic err);
    expT e;
    e.mask = mask; e.fa = fa; e.fb = fb;
    e.stall = stall; e.fD = fD; e.fE = fE;
    e.busy = busy; e.cnt = cnt; e.sc = sc; e.err = err;
    expQ.push_back(e);
    nameQ.push_back(name);
  endtask

  task automatic expFwd(input string n, input logic [1:0] fa, input logic [1:0] fb);
    checkOutput(n, 6'b000001, fa, fb, 1'b0, 1'b0, 1'b0, 32'h0, 4'd0, 16'd0, 1'b0);
  endtask

  task automatic expHaz(input string n, input logic stall, input logic fD, input logic fE);
    checkOutput(n, 6'b000010, 2'b00, 2'b00, stall, fD, fE, 32'h0, 4'd0, 16'd0, 1'b0);
  endtask

  task automatic expState(input string n, input logic [31:0] busy, input logic [3:0] cnt,
                          input logic [15:0] sc, input logic err);
    checkOutput(n, 6'b111100, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, busy, cnt, sc, err);
  endtask

  task automatic clearInputs();
    Rs1D = '0; Rs2D = '0; RdD = '0; LongD = 1'b0;
    Rs1E = '0; Rs2E = '0; RdE = '0; RegWriteE = 1'b0; LoadE = 1'b0; LongE = 1'b0;
    RdM = '0; RegWriteM = 1'b0; RdW = '0; RegWriteW = 1'b0;
    PCSrcE = 1'b0; MduDone = 1'b0; MduRd = '0;
  endtask

  // Advance to just after the next rising edge with idle inputs.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    clearInputs();
  endtask

  initial begin
    reset = 1'b0;
    clearInputs();
    applyStimulus();
    applyStimulus();
    expState("reset", 32'h0, 4'd0, 16'd0, 1'b0);
    expHaz("resetHaz", 1'b0, 1'b0, 1'b0);
    expFwd("resetFwd", 2'b00, 2'b00);
    applyStimulus();
    reset = 1'b1;

    // Forwarding
    applyStimulus();
    RegWriteM = 1; RdM = 5; Rs1E = 5; RegWriteW = 1; RdW = 6; Rs2E = 6;
    expFwd("fwdMW", 2'b10, 2'b01);
    expHaz("fwdNoStall", 1'b0, 1'b0, 1'b0);
    applyStimulus();
    RegWriteM = 1; RdM = 5; RegWriteW = 1; RdW = 5; Rs1E = 5; Rs2E = 5;
    expFwd("fwdPrio", 2'b10, 2'b10);
    applyStimulus();
    RegWriteM = 1; RdM = 0; RegWriteW = 1; RdW = 5; Rs1E = 0; Rs2E = 5;
    expFwd("fwdRdM0", 2'b00, 2'b01);
    applyStimulus();
    RegWriteM = 0; RdM = 5; RegWriteW = 0; RdW = 5; Rs1E = 5; Rs2E = 5;
    expFwd("fwdNoWrite", 2'b00, 2'b00);

    // Load-use
    applyStimulus();
    LoadE = 1; RdE = 7; Rs2D = 7;
    expHaz("loadUse", 1'b1, 1'b0, 1'b1);
    expState("preLoad", 32'h0, 4'd0, 16'd0, 1'b0);
    applyStimulus();
    expHaz("afterLoad", 1'b0, 1'b0, 1'b0);
    expState("loadCnt", 32'h0, 4'd0, 16'd1, 1'b0);
    applyStimulus();
    LoadE = 1; RdE = 0; Rs1D = 0;
    expHaz("loadX0", 1'b0, 1'b0, 1'b0);

    // Scoreboard RAW
    applyStimulus();
    LongE = 1; RegWriteE = 1; RdE = 9; Rs2D = 9;
    expHaz("longHit", 1'b1, 1'b0, 1'b1);
    expState("preIssue", 32'h0, 4'd0, 16'd1, 1'b0);
    applyStimulus();
    Rs1D = 9;
    expHaz("rawStall", 1'b1, 1'b0, 1'b1);
    expState("issued", 32'h200, 4'd1, 16'd2, 1'b0);
    applyStimulus();
    Rs1D = 9; MduDone = 1; MduRd = 9;
    expHaz("rawWait", 1'b1, 1'b0, 1'b1);
    expState("busyWait", 32'h200, 4'd1, 16'd3, 1'b0);
    applyStimulus();
    Rs1D = 9;
    expHaz("rawClear", 1'b0, 1'b0, 1'b0);
    expState("done", 32'h0, 4'd0, 16'd4, 1'b0);

    // MDU op writing x0: counted but never marked busy
    applyStimulus();
    LongE = 1; RegWriteE = 1; RdE = 0;
    expHaz("x0Issue", 1'b0, 1'b0, 1'b0);
    applyStimulus();
    MduDone = 1; MduRd = 0;
    expState("x0Busy", 32'h0, 4'd1, 16'd4, 1'b0);
    applyStimulus();
    MduDone = 1; MduRd = 6;
    expState("x0Done", 32'h0, 4'd0, 16'd4, 1'b0);
    applyStimulus();
    expState("errSpurious", 32'h0, 4'd0, 16'd4, 1'b1);

    // Capacity
    applyStimulus();
    LongE = 1; RegWriteE = 1; RdE = 1;
    applyStimulus();
    LongE = 1; RegWriteE = 1; RdE = 2;
    applyStimulus();
    LongE = 1; RegWriteE = 1; RdE = 3; LongD = 1;
    expHaz("fullBelow", 1'b0, 1'b0, 1'b0);
    expState("cnt2", 32'h6, 4'd2, 16'd4, 1'b1);
    applyStimulus();
    LongE = 1; RegWriteE = 1; RdE = 4; LongD = 1;
    expHaz("fullIssue", 1'b1, 1'b0, 1'b1);
    applyStimulus();
    LongD = 1; Rs1D = 10; Rs2D = 11; RdD = 12;
    expHaz("fullStall", 1'b1, 1'b0, 1'b1);
    expState("cnt4", 32'h1E, 4'd4, 16'd5, 1'b1);
    applyStimulus();
    Rs1D = 10; Rs2D = 11; RdD = 12;
    expHaz("fullIndep", 1'b0, 1'b0, 1'b0);
    applyStimulus();
    LongE = 1; RegWriteE = 1; RdE = 5; MduDone = 1; MduRd = 1;
    Rs1D = 10; Rs2D = 11; RdD = 12;
    expHaz("issueDone", 1'b0, 1'b0, 1'b0);

    // Branch during a scoreboard stall, then WAW
    applyStimulus();
    Rs1D = 2; PCSrcE = 1;
    expHaz("branchStall", 1'b1, 1'b1, 1'b1);
    expState("cnt4b", 32'h3C, 4'd4, 16'd6, 1'b1);
    applyStimulus();
    RdD = 3;
    expHaz("wawStall", 1'b1, 1'b0, 1'b1);
    applyStimulus();
    MduDone = 1; MduRd = 2;
    expHaz("noHaz", 1'b0, 1'b0, 1'b0);
    applyStimulus();
    expState("cnt3", 32'h38, 4'd3, 16'd8, 1'b1);

    // Asynchronous reset mid-operation, checked before the next rising edge
    applyStimulus();
    reset = 1'b0;
    expState("asyncReset", 32'h0, 4'd0, 16'd0, 1'b0);
    applyStimulus();
    reset = 1'b1;
    PCSrcE = 1;
    expHaz("branchOnly", 1'b0, 1'b1, 1'b1);
    expState("held", 32'h0, 4'd0, 16'd0, 1'b0);
    applyStimulus();
    applyStimulus();

    for (int i = 0; i < 10 && expQ.size() > 0; i++)
      @(posedge clk);
    if (expQ.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
